mealy_ctx_sched: RTL and testbench
==================================

MEALY_CTX_SCHED -- requirements
Module: mealy_ctx_sched

Interface
- REQ-001 Parameter N_CH, default 4, meaning number of requester channels (legal 2..8).
- REQ-002 Parameter PTR_W, default 2, meaning channel-index width, equal to clog2(N_CH).
- REQ-003 clk  input  1  clock; all state updates on posedge clk.
- REQ-004 rst  input  1  reset, synchronous, active-high.
- REQ-005 req  input  N_CH  per-channel step request, level-sensitive.
- REQ-006 inp  input  N_CH  per-channel step input bit, sampled for the granted channel only.
- REQ-007 gnt  output  N_CH  registered one-hot grant; all-zero when no step issued.
- REQ-008 vld  output  1  registered; high the cycle after a step is executed.
- REQ-009 out  output  1  registered Mealy output of the executed step; valid when vld=1.
- REQ-010 ch  output  PTR_W  registered index of the granted channel; valid when vld=1.

Function
- REQ-011 Block SHALL time-share one 4-phase Mealy step engine across N_CH channels, holding per-channel context: phase (2 bits) and last output (1 bit).
- REQ-012 Phases SHALL be OFF=00, ON1=01, ON2=10, ON3=11.
- REQ-013 Step table (phase,inp -> next phase/out) SHALL be: OFF,0->OFF/1; OFF,1->ON1/0; ON1,1->ON2/1; ON2,1->ON3/1; ON3,1->OFF/0.
- REQ-014 ON1/ON2/ON3 with inp=0 SHALL hold phase and output the channel's stored last output.
- REQ-015 Illegal phase encoding is impossible by construction; step engine default branch SHALL yield OFF/0.
- REQ-016 Each cycle with req!=0, exactly one channel SHALL be granted, round-robin, searching upward from (last granted index + 1) modulo N_CH.
- REQ-017 Granted channel's context SHALL update at the same posedge that registers gnt/vld/out/ch; latency req-sample to vld is 1 cycle.
- REQ-018 Non-granted channels' contexts SHALL remain unchanged.
- REQ-019 req=0 in a cycle: next cycle gnt=0, vld=0, out and ch hold previous values, pointer unchanged.
- REQ-020 Single requester held high SHALL be granted every cycle (one step per cycle, back-to-back).
- REQ-021 All N_CH requesting continuously SHALL each be granted exactly once per N_CH cycles.
- REQ-022 Pointer wrap: after granting index N_CH-1, search SHALL start at 0.
- REQ-023 A requester dropping req in the cycle it would be selected SHALL not be granted; no step is taken for it.

Reset
- REQ-024 rst SHALL set all phases to OFF, all stored outputs to 0, gnt=0, vld=0, out=0, ch=0.
- REQ-025 rst SHALL set the last-granted pointer to N_CH-1, so channel 0 has first priority.
- REQ-026 rst asserted mid-stream SHALL override any pending step; no vld in the cycle following rst.

Configuration
- REQ-027 Macro MEALY_CTX_SCHED_GNT_CNT_EN, when defined, SHALL add output gnt_cnt (N_CH x 8 bits, flattened): per-channel saturating grant count, reset to 0, increments with each grant, sticks at 255.
- REQ-028 Without MEALY_CTX_SCHED_GNT_CNT_EN, port gnt_cnt and its counters SHALL not exist; all other behaviour identical.

Structure
- REQ-029 Package mealy_ctx_pkg SHALL hold phase constants OFF/ON1/ON2/ON3 and phase width 2.
- REQ-030 Sub-module mealy_step SHALL implement REQ-013..015 combinationally (inputs phase, inp, last_out; outputs next phase, out); instantiated once.
- REQ-031 Round-robin selection, context arrays and output registers SHALL reside in mealy_ctx_sched.

Verification
- REQ-032 Reset then req=0001, inp=0001 for 4 cycles -> ch0 out sequence 0,1,1,0; ch0 phase back to OFF; vld high cycles 2..5.
- REQ-033 req=1111 constant 8 cycles -> ch sequence 0,1,2,3,0,1,2,3; gnt one-hot each cycle.
- REQ-034 ch2 stepped to ON2 (inp=1 twice), then req=0100, inp=0000 -> out=1, phase stays ON2; then OFF channel ch1 with inp=0 -> out=1, phase OFF.
- REQ-035 Interleaved req=0011 with inp=0001 -> ch0 advances OFF->ON1->ON2, ch1 stays OFF emitting 1; contexts independent.
- REQ-036 rst asserted while req=1111 mid-rotation -> next cycle vld=0, gnt=0; first grant after release is ch0, all phases OFF.
- REQ-037 With MEALY_CTX_SCHED_GNT_CNT_EN, req=0001 for 300 cycles -> gnt_cnt ch0 = 255, others 0.

Source files
------------

// File: rtl/mealy_ctx_sched_pkg.sv
// ----------------------------------------------------------------------------
// mealy_ctx_pkg
// Shared definitions for the time-shared Mealy step scheduler.
//   PHASE_W : width of a channel's phase context
//   phase_t : OFF/ON1/ON2/ON3 phase encoding
// ----------------------------------------------------------------------------
package mealy_ctx_pkg;

    localparam int PHASE_W = 2;

    typedef enum logic [PHASE_W-1:0] {
        OFF = 2'b00,
        ON1 = 2'b01,
        ON2 = 2'b10,
        ON3 = 2'b11
    } phase_t;

endpackage

// File: rtl/mealy_ctx_sched_if.sv
// ----------------------------------------------------------------------------
// mealy_ctx_sched_if
// Request/grant bundle of the scheduler.
//   req : per-channel step request (level)
//   inp : per-channel step input bit
//   gnt : one-hot grant of the executed step
//   vld : a step was executed in the previous cycle
//   out : Mealy output of that step
//   ch  : index of the granted channel
// master drives req/inp, slave (the scheduler) drives the results.
// ----------------------------------------------------------------------------
interface mealy_ctx_sched_if #(
    parameter int N_CH  = 4,
    parameter int PTR_W = 2
);
    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  inp;
    logic [N_CH-1:0]  gnt;
    logic             vld;
    logic             out;
    logic [PTR_W-1:0] ch;

    modport master (output req, output inp, input gnt, input vld, input out, input ch);
    modport slave  (input req, input inp, output gnt, output vld, output out, output ch);
endinterface

// File: rtl/mealy_ctx_sched_step.sv
// ----------------------------------------------------------------------------
// mealy_step
// Combinational 4-phase Mealy step engine shared by all channels.
//   phase_i     : current phase of the selected channel
//   inp_i       : step input bit
//   last_out_i  : channel's previously emitted output
//   nxt_phase_o : phase after the step
//   out_o       : output produced by the step
// ----------------------------------------------------------------------------
module mealy_step
    import mealy_ctx_pkg::*;
(
    input  phase_t phase_i,
    input  logic   inp_i,
    input  logic   last_out_i,
    output phase_t nxt_phase_o,
    output logic   out_o
);

    // Step table; ON phases with inp=0 hold and replay the stored output.
    always_comb begin
        nxt_phase_o = OFF;
        out_o       = 1'b0;
        case (phase_i)
            OFF: begin
                if (inp_i) begin
                    nxt_phase_o = ON1;
                    out_o       = 1'b0;
                end else begin
                    nxt_phase_o = OFF;
                    out_o       = 1'b1;
                end
            end
            ON1: begin
                if (inp_i) begin
                    nxt_phase_o = ON2;
                    out_o       = 1'b1;
                end else begin
                    nxt_phase_o = ON1;
                    out_o       = last_out_i;
                end
            end
            ON2: begin
                if (inp_i) begin
                    nxt_phase_o = ON3;
                    out_o       = 1'b1;
                end else begin
                    nxt_phase_o = ON2;
                    out_o       = last_out_i;
                end
            end
            ON3: begin
                if (inp_i) begin
                    nxt_phase_o = OFF;
                    out_o       = 1'b0;
                end else begin
                    nxt_phase_o = ON3;
                    out_o       = last_out_i;
                end
            end
            default: begin
                nxt_phase_o = OFF;
                out_o       = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mealy_ctx_sched.sv
// ----------------------------------------------------------------------------
// mealy_ctx_sched
// Round-robin time-sharing of one Mealy step engine across N_CH channels,
// each holding its own phase and last-output context.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mealy_ctx_sched_if.slave (req/inp in, gnt/vld/out/ch out)
//   gnt_cnt  : per-channel saturating 8-bit grant counters, flattened
//              (only when MEALY_CTX_SCHED_GNT_CNT_EN is defined)
// ----------------------------------------------------------------------------
module mealy_ctx_sched
    import mealy_ctx_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int PTR_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    mealy_ctx_sched_if.slave    bus
`ifdef MEALY_CTX_SCHED_GNT_CNT_EN
    ,
    output logic [N_CH*8-1:0]   gnt_cnt
`endif
);

    phase_t           phase_q [N_CH];
    phase_t           phase_d [N_CH];
    logic             last_q  [N_CH];
    logic             last_d  [N_CH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [N_CH-1:0]  gnt_q, gnt_d;
    logic             vld_q, vld_d;
    logic             out_q, out_d;
    logic [PTR_W-1:0] ch_q, ch_d;

    logic             sel_found_s;
    logic [PTR_W-1:0] sel_idx_s;
    phase_t           step_nxt_s;
    logic             step_out_s;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand     = (int'(ptr_q) + i) % N_CH;
            cand_idx = PTR_W'(cand);
            if (!sel_found_s && bus.req[cand_idx]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_idx;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    mealy_step u_step (
        .phase_i     (phase_q[sel_idx_s]),
        .inp_i       (bus.inp[sel_idx_s]),
        .last_out_i  (last_q[sel_idx_s]),
        .nxt_phase_o (step_nxt_s),
        .out_o       (step_out_s)
    );

    // Next-state: only the granted channel's context moves; idle cycles hold out/ch/ptr.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            phase_d[i] = phase_q[i];
            last_d[i]  = last_q[i];
        end
        gnt_d = '0;
        vld_d = 1'b0;
        out_d = out_q;
        ch_d  = ch_q;
        ptr_d = ptr_q;
        if (sel_found_s) begin
            phase_d[sel_idx_s] = step_nxt_s;
            last_d[sel_idx_s]  = step_out_s;
            gnt_d              = {{(N_CH-1){1'b0}}, 1'b1} << sel_idx_s;
            vld_d              = 1'b1;
            out_d              = step_out_s;
            ch_d               = sel_idx_s;
            ptr_d              = sel_idx_s;
        end else begin
            gnt_d = '0;
            vld_d = 1'b0;
        end
    end

    // State and output registers; reset parks the pointer on N_CH-1 so ch0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                phase_q[i] <= OFF;
                last_q[i]  <= 1'b0;
            end
            ptr_q <= PTR_W'(N_CH - 1);
            gnt_q <= '0;
            vld_q <= 1'b0;
            out_q <= 1'b0;
            ch_q  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                phase_q[i] <= phase_d[i];
                last_q[i]  <= last_d[i];
            end
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
            vld_q <= vld_d;
            out_q <= out_d;
            ch_q  <= ch_d;
        end
    end

    assign bus.gnt = gnt_q;
    assign bus.vld = vld_q;
    assign bus.out = out_q;
    assign bus.ch  = ch_q;

`ifdef MEALY_CTX_SCHED_GNT_CNT_EN
    logic [7:0] cnt_q [N_CH];

    // Saturating grant counters, sticking at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (gnt_d[i] && (cnt_q[i] != 8'd255)) begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end else begin
                    cnt_q[i] <= cnt_q[i];
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt
        assign gnt_cnt[g*8 +: 8] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_mealy_ctx_sched.sv
// ----------------------------------------------------------------------------
// tb_mealy_ctx_sched
// Directed scenarios plus randomized traffic against a behavioural model of
// the scheduler (integer phases, arithmetic step rule, round-robin scan).
// ----------------------------------------------------------------------------
module tb_mealy_ctx_sched;

    localparam int N  = 4;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mealy_ctx_sched_if #(.N_CH(N), .PTR_W(PW)) bus ();

`ifdef MEALY_CTX_SCHED_GNT_CNT_EN
    logic [N*8-1:0] gnt_cnt;
`endif

    mealy_ctx_sched #(.N_CH(N), .PTR_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEALY_CTX_SCHED_GNT_CNT_EN
        ,
        .gnt_cnt (gnt_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference context: phase as 0..3, last output, pointer, grant counts.
    int m_phase [N];
    int m_last  [N];
    int m_cnt   [N];
    int m_ptr;
    logic [N-1:0]  e_gnt;
    logic          e_vld;
    logic          e_out;
    logic [PW-1:0] e_ch;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_phase[i] = 0;
            m_last[i]  = 0;
            m_cnt[i]   = 0;
        end
        m_ptr = N - 1;
        e_gnt = '0;
        e_vld = 1'b0;
        e_out = 1'b0;
        e_ch  = '0;
    endtask

    // One clock: apply inputs, advance the model, check all outputs after the edge.
    task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N-1:0] ip);
        int found;
        int c;
        int p;
        int o;
        @(negedge clk);
        rst     = r;
        bus.req = rq;
        bus.inp = ip;
        if (r) begin
            model_reset();
        end else begin
            found = -1;
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (found < 0 && rq[c]) found = c;
            end
            if (found >= 0) begin
                p = m_phase[found];
                if (ip[found]) begin
                    o = (p == 1 || p == 2) ? 1 : 0;
                    m_phase[found] = (p + 1) % 4;
                end else begin
                    o = (p == 0) ? 1 : m_last[found];
                end
                m_last[found] = o;
                if (m_cnt[found] < 255) m_cnt[found]++;
                e_gnt = '0;
                e_gnt[found] = 1'b1;
                e_vld = 1'b1;
                e_out = o[0];
                e_ch  = PW'(found);
                m_ptr = found;
            end else begin
                e_gnt = '0;
                e_vld = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_val("gnt", bus.gnt, e_gnt);
        check_val("vld", bus.vld, e_vld);
        check_val("out", bus.out, e_out);
        check_val("ch",  bus.ch,  e_ch);
    endtask

    logic [N-1:0] rq_r;
    logic [N-1:0] ip_r;
    logic         rs_r;
    logic [3:0]   exp_out_seq;

    initial begin
        rst     = 1'b1;
        bus.req = '0;
        bus.inp = '0;
        model_reset();

        // Reset state.
        cyc(1'b1, 4'b0000, 4'b0000);
        cyc(1'b1, 4'b1111, 4'b1111);
        check_val("rst_gnt", bus.gnt, 32'd0);
        check_val("rst_vld", bus.vld, 32'd0);
        check_val("rst_out", bus.out, 32'd0);
        check_val("rst_ch",  bus.ch,  32'd0);

        // Single channel walking the full phase cycle: outputs 0,1,1,0.
        cyc(1'b1, 4'b0000, 4'b0000);
        exp_out_seq = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 4'b0001, 4'b0001);
            check_val("seq_vld", bus.vld, 32'd1);
            check_val("seq_out", bus.out, {31'd0, exp_out_seq[3-i]});
        end
        cyc(1'b0, 4'b0001, 4'b0000);
        check_val("seq_off", bus.out, 32'd1);
        cyc(1'b0, 4'b0000, 4'b0000);
        check_val("idle_vld", bus.vld, 32'd0);
        check_val("idle_out", bus.out, 32'd1);

        // All channels requesting: strict rotation 0..3 with one-hot grant.
        cyc(1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 4'b1111, 4'b0000);
            check_val("rr_ch",  bus.ch, i % 4);
            check_val("onehot", {31'd0, $onehot(bus.gnt)}, 32'd1);
        end

        // ch2 to ON2, then hold with inp=0, then OFF channel ch1.
        cyc(1'b1, 4'b0000, 4'b0000);
        cyc(1'b0, 4'b0100, 4'b0100);
        cyc(1'b0, 4'b0100, 4'b0100);
        cyc(1'b0, 4'b0100, 4'b0000);
        check_val("hold_out", bus.out, 32'd1);
        check_val("hold_ch",  bus.ch,  32'd2);
        cyc(1'b0, 4'b0010, 4'b0000);
        check_val("off_out", bus.out, 32'd1);
        check_val("off_ch",  bus.ch,  32'd1);
        cyc(1'b0, 4'b0100, 4'b0100);
        check_val("on3_out", bus.out, 32'd1);
        cyc(1'b0, 4'b0100, 4'b0100);
        check_val("wrap_out", bus.out, 32'd0);

        // Interleaved ch0/ch1: ch0 advances, ch1 stays OFF emitting 1.
        cyc(1'b1, 4'b0000, 4'b0000);
        exp_out_seq = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 4'b0011, 4'b0001);
            check_val("il_ch",  bus.ch, i % 2);
            check_val("il_out", bus.out, {31'd0, exp_out_seq[3-i]});
        end

        // Reset mid-rotation overrides the pending step.
        cyc(1'b1, 4'b0000, 4'b0000);
        cyc(1'b0, 4'b1111, 4'b1111);
        cyc(1'b0, 4'b1111, 4'b1111);
        cyc(1'b1, 4'b1111, 4'b1111);
        check_val("mrst_vld", bus.vld, 32'd0);
        check_val("mrst_gnt", bus.gnt, 32'd0);
        cyc(1'b0, 4'b1111, 4'b1111);
        check_val("mrst_ch",  bus.ch,  32'd0);
        check_val("mrst_out", bus.out, 32'd0);
        cyc(1'b0, 4'b1111, 4'b1111);
        check_val("mrst_ch1", bus.ch,  32'd1);
        check_val("mrst_o1",  bus.out, 32'd0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            rq_r = N'($urandom);
            ip_r = N'($urandom);
            rs_r = ($urandom_range(0, 49) == 0);
            cyc(rs_r, rq_r, ip_r);
        end

`ifdef MEALY_CTX_SCHED_GNT_CNT_EN
        // Saturating grant counter.
        cyc(1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 4'b0001, N'($urandom));
        end
        check_val("cnt0", {24'd0, gnt_cnt[7:0]},   32'd255);
        check_val("cnt1", {24'd0, gnt_cnt[15:8]},  32'd0);
        check_val("cnt2", {24'd0, gnt_cnt[23:16]}, 32'd0);
        check_val("cnt3", {24'd0, gnt_cnt[31:24]}, 32'd0);
        for (int i = 0; i < N; i++) begin
            check_val("cnt_model", {24'd0, gnt_cnt[i*8 +: 8]}, m_cnt[i]);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
